// File: rtl/difftest_pkg.sv
// Shared constants and state encoding for the difftest commit front end.
package difftest_pkg;

    localparam int unsigned XLEN    = 64;
    localparam int unsigned ILEN    = 32;
    localparam int unsigned WDEST_W = 8;

    localparam logic [31:0] GOOD_TRAP_INST = 32'h0000006b;

    typedef enum logic [0:0] {
        StRun,
        StHalt
    } commit_state_e;

endpackage

// File: rtl/commit_lane_pack.sv
// Combinational lane compactor: moves accepted lanes down to contiguous output slots
// in ascending lane order and reports how many were accepted.
module commit_lane_pack #(
    parameter int unsigned NCOMMIT = 2,
    parameter int unsigned XLEN    = difftest_pkg::XLEN,
    parameter int unsigned ILEN    = difftest_pkg::ILEN,
    parameter int unsigned WDEST_W = difftest_pkg::WDEST_W
) (
    input  logic [NCOMMIT-1:0]         accept,
    input  logic [NCOMMIT*XLEN-1:0]    in_pc,
    input  logic [NCOMMIT*ILEN-1:0]    in_instr,
    input  logic [NCOMMIT-1:0]         in_skip,
    input  logic [NCOMMIT-1:0]         in_wen,
    input  logic [NCOMMIT*WDEST_W-1:0] in_wdest,
    input  logic [NCOMMIT*XLEN-1:0]    in_wdata,
    output logic [NCOMMIT-1:0]         pack_valid,
    output logic [NCOMMIT*XLEN-1:0]    pack_pc,
    output logic [NCOMMIT*ILEN-1:0]    pack_instr,
    output logic [NCOMMIT-1:0]         pack_skip,
    output logic [NCOMMIT-1:0]         pack_wen,
    output logic [NCOMMIT*WDEST_W-1:0] pack_wdest,
    output logic [NCOMMIT*XLEN-1:0]    pack_wdata,
    output logic [$clog2(NCOMMIT+1)-1:0] accept_cnt
);

    localparam int unsigned CntW = $clog2(NCOMMIT + 1);

    always_comb begin
        int slot;
        pack_valid = '0;
        pack_pc    = '0;
        pack_instr = '0;
        pack_skip  = '0;
        pack_wen   = '0;
        pack_wdest = '0;
        pack_wdata = '0;
        slot       = 0;
        for (int i = 0; i < int'(NCOMMIT); i++) begin
            if (accept[i]) begin
                // Constant slot index per unrolled k keeps the selects static.
                for (int k = 0; k < int'(NCOMMIT); k++) begin
                    if (k == slot) begin
                        pack_valid[k]                    = 1'b1;
                        pack_pc[k*XLEN +: XLEN]          = in_pc[i*XLEN +: XLEN];
                        pack_instr[k*ILEN +: ILEN]       = in_instr[i*ILEN +: ILEN];
                        pack_skip[k]                     = in_skip[i];
                        pack_wen[k]                      = in_wen[i];
                        pack_wdest[k*WDEST_W +: WDEST_W] = in_wdest[i*WDEST_W +: WDEST_W];
                        pack_wdata[k*XLEN +: XLEN]       = in_wdata[i*XLEN +: XLEN];
                    end
                end
                slot = slot + 1;
            end
        end
        accept_cnt = CntW'(slot);
    end

endmodule

// File: rtl/difftest_commit_pack.sv
// Multi-lane retirement front end: filters empty/duplicate lanes, packs and registers them,
// and counts cycles and instructions. Good-trap halt exists only with DIFFTEST_TRAP_EN.
module difftest_commit_pack #(
    parameter int unsigned NCOMMIT = 2,
    parameter int unsigned XLEN    = difftest_pkg::XLEN,
    parameter int unsigned ILEN    = difftest_pkg::ILEN
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic [NCOMMIT-1:0]                        in_valid,
    input  logic [NCOMMIT*XLEN-1:0]                   in_pc,
    input  logic [NCOMMIT*ILEN-1:0]                   in_instr,
    input  logic [NCOMMIT-1:0]                        in_skip,
    input  logic [NCOMMIT-1:0]                        in_wen,
    input  logic [NCOMMIT*difftest_pkg::WDEST_W-1:0]  in_wdest,
    input  logic [NCOMMIT*XLEN-1:0]                   in_wdata,
    input  logic [XLEN-1:0]                           trap_a0,
    output logic [NCOMMIT-1:0]                        out_valid,
    output logic [NCOMMIT*XLEN-1:0]                   out_pc,
    output logic [NCOMMIT*ILEN-1:0]                   out_instr,
    output logic [NCOMMIT-1:0]                        out_skip,
    output logic [NCOMMIT-1:0]                        out_wen,
    output logic [NCOMMIT*difftest_pkg::WDEST_W-1:0]  out_wdest,
    output logic [NCOMMIT*XLEN-1:0]                   out_wdata,
    output logic [63:0]                               cycle_cnt,
`ifdef DIFFTEST_TRAP_EN
    output logic                                      trap_valid,
    output logic [7:0]                                trap_code,
    output logic [XLEN-1:0]                           trap_pc,
`endif
    output logic [63:0]                               instr_cnt
);

    import difftest_pkg::*;

    localparam int unsigned CntW = $clog2(NCOMMIT + 1);

    logic                  halted;
    logic [NCOMMIT-1:0]    accept;
    logic [XLEN-1:0]       last_pc_q, last_pc_d;
    logic                  last_pc_vld_q, last_pc_vld_d;
    logic                  trap_hit;
    logic [XLEN-1:0]       trap_hit_pc;

    logic [NCOMMIT-1:0]          pack_valid;
    logic [NCOMMIT*XLEN-1:0]     pack_pc;
    logic [NCOMMIT*ILEN-1:0]     pack_instr;
    logic [NCOMMIT-1:0]          pack_skip;
    logic [NCOMMIT-1:0]          pack_wen;
    logic [NCOMMIT*WDEST_W-1:0]  pack_wdest;
    logic [NCOMMIT*XLEN-1:0]     pack_wdata;
    logic [CntW-1:0]             accept_cnt;

    logic [NCOMMIT-1:0]          out_valid_q;
    logic [NCOMMIT*XLEN-1:0]     out_pc_q;
    logic [NCOMMIT*ILEN-1:0]     out_instr_q;
    logic [NCOMMIT-1:0]          out_skip_q;
    logic [NCOMMIT-1:0]          out_wen_q;
    logic [NCOMMIT*WDEST_W-1:0]  out_wdest_q;
    logic [NCOMMIT*XLEN-1:0]     out_wdata_q;
    logic [63:0]                 cycle_cnt_q;
    logic [63:0]                 instr_cnt_q;

    // Without the trap feature the upper a0 bits (or all of them) go nowhere.
    logic unused_trap_a0;
    assign unused_trap_a0 = ^trap_a0;

    // Running last-PC scan: each accepted lane becomes the reference for the lanes above it.
    always_comb begin
        logic blocked;
        accept        = '0;
        last_pc_d     = last_pc_q;
        last_pc_vld_d = last_pc_vld_q;
        trap_hit      = 1'b0;
        trap_hit_pc   = '0;
        blocked       = halted;
        for (int i = 0; i < int'(NCOMMIT); i++) begin
            if (!blocked && in_valid[i] && (in_instr[i*ILEN +: ILEN] != '0) &&
                !(last_pc_vld_d && (in_pc[i*XLEN +: XLEN] == last_pc_d))) begin
                accept[i]     = 1'b1;
                last_pc_d     = in_pc[i*XLEN +: XLEN];
                last_pc_vld_d = 1'b1;
`ifdef DIFFTEST_TRAP_EN
                if (in_instr[i*ILEN +: ILEN] == ILEN'(GOOD_TRAP_INST)) begin
                    trap_hit    = 1'b1;
                    trap_hit_pc = in_pc[i*XLEN +: XLEN];
                    blocked     = 1'b1;
                end
`endif
            end
        end
    end

`ifdef DIFFTEST_TRAP_EN
    commit_state_e state_q, state_d;
    logic [7:0]    trap_code_q;
    logic [XLEN-1:0] trap_pc_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:   if (trap_hit) state_d = StHalt;
            StHalt:  state_d = StHalt;
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StRun;
            trap_code_q <= '0;
            trap_pc_q   <= '0;
        end else begin
            state_q <= state_d;
            if (trap_hit) begin
                trap_code_q <= trap_a0[7:0];
                trap_pc_q   <= trap_hit_pc;
            end
        end
    end

    assign halted     = (state_q == StHalt);
    assign trap_valid = halted;
    assign trap_code  = trap_code_q;
    assign trap_pc    = trap_pc_q;
`else
    logic unused_trap_hit;
    assign unused_trap_hit = trap_hit | (^trap_hit_pc);
    assign halted          = 1'b0;
`endif

    commit_lane_pack #(
        .NCOMMIT (NCOMMIT),
        .XLEN    (XLEN),
        .ILEN    (ILEN),
        .WDEST_W (WDEST_W)
    ) u_pack (
        .accept     (accept),
        .in_pc      (in_pc),
        .in_instr   (in_instr),
        .in_skip    (in_skip),
        .in_wen     (in_wen),
        .in_wdest   (in_wdest),
        .in_wdata   (in_wdata),
        .pack_valid (pack_valid),
        .pack_pc    (pack_pc),
        .pack_instr (pack_instr),
        .pack_skip  (pack_skip),
        .pack_wen   (pack_wen),
        .pack_wdest (pack_wdest),
        .pack_wdata (pack_wdata),
        .accept_cnt (accept_cnt)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid_q   <= '0;
            out_pc_q      <= '0;
            out_instr_q   <= '0;
            out_skip_q    <= '0;
            out_wen_q     <= '0;
            out_wdest_q   <= '0;
            out_wdata_q   <= '0;
            last_pc_q     <= '0;
            last_pc_vld_q <= 1'b0;
            cycle_cnt_q   <= '0;
            instr_cnt_q   <= '0;
        end else begin
            out_valid_q   <= pack_valid;
            out_pc_q      <= pack_pc;
            out_instr_q   <= pack_instr;
            out_skip_q    <= pack_skip;
            out_wen_q     <= pack_wen;
            out_wdest_q   <= pack_wdest;
            out_wdata_q   <= pack_wdata;
            last_pc_q     <= last_pc_d;
            last_pc_vld_q <= last_pc_vld_d;
            if (!halted) begin
                cycle_cnt_q <= cycle_cnt_q + 64'd1;
            end
            instr_cnt_q <= instr_cnt_q + 64'(accept_cnt);
        end
    end

    assign out_valid = out_valid_q;
    assign out_pc    = out_pc_q;
    assign out_instr = out_instr_q;
    assign out_skip  = out_skip_q;
    assign out_wen   = out_wen_q;
    assign out_wdest = out_wdest_q;
    assign out_wdata = out_wdata_q;
    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_difftest_commit_pack.sv
// Randomized bench for difftest_commit_pack against a queue-based reference model;
// trap checks are compiled in when DIFFTEST_TRAP_EN is defined.
module tb_difftest_commit_pack;

    localparam int unsigned NC = 2;
    localparam int unsigned XL = 64;
    localparam int unsigned IL = 32;
    localparam int unsigned WD = 8;
    localparam logic [31:0] TRAP = 32'h0000006b;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [NC-1:0]     in_valid, in_skip, in_wen;
    logic [NC*XL-1:0]  in_pc, in_wdata;
    logic [NC*IL-1:0]  in_instr;
    logic [NC*WD-1:0]  in_wdest;
    logic [XL-1:0]     trap_a0;
    logic [NC-1:0]     out_valid, out_skip, out_wen;
    logic [NC*XL-1:0]  out_pc, out_wdata;
    logic [NC*IL-1:0]  out_instr;
    logic [NC*WD-1:0]  out_wdest;
    logic [63:0]       cycle_cnt, instr_cnt;
`ifdef DIFFTEST_TRAP_EN
    logic              trap_valid;
    logic [7:0]        trap_code;
    logic [XL-1:0]     trap_pc;
`endif

    difftest_commit_pack #(
        .NCOMMIT (NC),
        .XLEN    (XL),
        .ILEN    (IL)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_pc      (in_pc),
        .in_instr   (in_instr),
        .in_skip    (in_skip),
        .in_wen     (in_wen),
        .in_wdest   (in_wdest),
        .in_wdata   (in_wdata),
        .trap_a0    (trap_a0),
        .out_valid  (out_valid),
        .out_pc     (out_pc),
        .out_instr  (out_instr),
        .out_skip   (out_skip),
        .out_wen    (out_wen),
        .out_wdest  (out_wdest),
        .out_wdata  (out_wdata),
        .cycle_cnt  (cycle_cnt),
`ifdef DIFFTEST_TRAP_EN
        .trap_valid (trap_valid),
        .trap_code  (trap_code),
        .trap_pc    (trap_pc),
`endif
        .instr_cnt  (instr_cnt)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [XL-1:0] m_last;
    bit            m_vld, m_halt;
    logic [63:0]   m_cyc, m_icnt;
    logic [7:0]    m_trap_code;
    logic [XL-1:0] m_trap_pc;
    logic [NC-1:0] e_valid, e_skip, e_wen;
    logic [XL-1:0] e_pc [NC];
    logic [IL-1:0] e_instr [NC];
    logic [WD-1:0] e_wdest [NC];
    logic [XL-1:0] e_wdata [NC];

    task automatic model_reset();
        m_last = '0; m_vld = 0; m_halt = 0; m_cyc = '0; m_icnt = '0;
        m_trap_code = '0; m_trap_pc = '0;
        e_valid = '0; e_skip = '0; e_wen = '0;
        for (int k = 0; k < NC; k++) begin
            e_pc[k] = '0; e_instr[k] = '0; e_wdest[k] = '0; e_wdata[k] = '0;
        end
    endtask

    // Walk lanes oldest first, keep the survivors in a queue, then lay them out in order.
    task automatic model_step();
        int acc[$];
        bit stop;
        stop = m_halt;
        if (!m_halt) m_cyc = m_cyc + 64'd1;
        for (int i = 0; i < NC; i++) begin
            logic [XL-1:0] pc;
            logic [IL-1:0] ins;
            pc  = in_pc[i*XL +: XL];
            ins = in_instr[i*IL +: IL];
            if (!stop && in_valid[i] && ins != '0 && !(m_vld && pc == m_last)) begin
                acc.push_back(i);
                m_last = pc;
                m_vld  = 1;
`ifdef DIFFTEST_TRAP_EN
                if (ins == TRAP) begin
                    stop        = 1;
                    m_halt      = 1;
                    m_trap_code = trap_a0[7:0];
                    m_trap_pc   = pc;
                end
`endif
            end
        end
        m_icnt = m_icnt + 64'(acc.size());
        e_valid = '0; e_skip = '0; e_wen = '0;
        for (int k = 0; k < NC; k++) begin
            e_pc[k] = '0; e_instr[k] = '0; e_wdest[k] = '0; e_wdata[k] = '0;
            if (k < acc.size()) begin
                e_valid[k]  = 1'b1;
                e_pc[k]     = in_pc[acc[k]*XL +: XL];
                e_instr[k]  = in_instr[acc[k]*IL +: IL];
                e_skip[k]   = in_skip[acc[k]];
                e_wen[k]    = in_wen[acc[k]];
                e_wdest[k]  = in_wdest[acc[k]*WD +: WD];
                e_wdata[k]  = in_wdata[acc[k]*XL +: XL];
            end
        end
    endtask

    task automatic check_all(input string ph);
        check_eq({ph, ".out_valid"}, 64'(out_valid), 64'(e_valid));
        for (int k = 0; k < NC; k++) begin
            check_eq($sformatf("%s.pc%0d", ph, k), out_pc[k*XL +: XL], e_pc[k]);
            check_eq($sformatf("%s.instr%0d", ph, k), 64'(out_instr[k*IL +: IL]), 64'(e_instr[k]));
            check_eq($sformatf("%s.skip%0d", ph, k), 64'(out_skip[k]), 64'(e_skip[k]));
            check_eq($sformatf("%s.wen%0d", ph, k), 64'(out_wen[k]), 64'(e_wen[k]));
            check_eq($sformatf("%s.wdest%0d", ph, k), 64'(out_wdest[k*WD +: WD]), 64'(e_wdest[k]));
            check_eq($sformatf("%s.wdata%0d", ph, k), out_wdata[k*XL +: XL], e_wdata[k]);
        end
        check_eq({ph, ".cycle_cnt"}, cycle_cnt, m_cyc);
        check_eq({ph, ".instr_cnt"}, instr_cnt, m_icnt);
`ifdef DIFFTEST_TRAP_EN
        check_eq({ph, ".trap_valid"}, 64'(trap_valid), 64'(m_halt));
        check_eq({ph, ".trap_code"}, 64'(trap_code), 64'(m_trap_code));
        check_eq({ph, ".trap_pc"}, trap_pc, m_trap_pc);
`endif
    endtask

    task automatic set_lane(input int i, input bit v, input logic [XL-1:0] pc,
                            input logic [IL-1:0] ins);
        in_valid[i]          = v;
        in_pc[i*XL +: XL]    = pc;
        in_instr[i*IL +: IL] = ins;
        in_skip[i]           = 1'($urandom_range(0, 1));
        in_wen[i]            = 1'($urandom_range(0, 1));
        in_wdest[i*WD +: WD] = 8'($urandom);
        in_wdata[i*XL +: XL] = {$urandom, $urandom};
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input string ph);
        @(posedge clock);
        model_step();
        #1;
        check_all(ph);
        @(negedge clock);
    endtask

    logic [63:0] cyc0, icnt0;

    initial begin
        in_valid = '0; in_skip = '0; in_wen = '0; in_pc = '0; in_wdata = '0;
        in_instr = '0; in_wdest = '0; trap_a0 = '0;
        model_reset();

        // Reset held across an edge: everything zero.
        @(negedge clock);
        check_all("reset");
        reset = 1'b0;

        // Test 1: first instruction after reset.
        set_lane(0, 1, 64'h8000_0000, 32'h0000_0093);
        set_lane(1, 0, 64'h0, 32'h0);
        step("t1");
        check_eq("t1.valid_const", 64'(out_valid), 64'b01);
        check_eq("t1.pc_const", out_pc[XL-1:0], 64'h8000_0000);
        check_eq("t1.icnt_const", instr_cnt, 64'd1);

        // Test 2: only lane1 valid gets packed into lane 0.
        set_lane(0, 0, 64'h8000_0000, 32'h0000_0093);
        set_lane(1, 1, 64'h8000_0004, 32'h0000_0013);
        step("t2");
        check_eq("t2.valid_const", 64'(out_valid), 64'b01);
        check_eq("t2.pc_const", out_pc[XL-1:0], 64'h8000_0004);

        // Test 3: writeback stalled for three cycles on one PC.
        cyc0  = m_cyc;
        icnt0 = m_icnt;
        set_lane(0, 1, 64'h8000_0008, 32'h0000_0113);
        set_lane(1, 0, 64'h0, 32'h0);
        for (int c = 0; c < 3; c++) step("t3");
        check_eq("t3.icnt_delta", instr_cnt - icnt0, 64'd1);
        check_eq("t3.cyc_delta", cycle_cnt - cyc0, 64'd3);

        // Test 4: same-cycle duplicate, then a zero instruction.
        set_lane(0, 1, 64'h8000_000c, 32'h0000_0193);
        set_lane(1, 1, 64'h8000_000c, 32'h0000_0193);
        step("t4a");
        check_eq("t4a.valid_const", 64'(out_valid), 64'b01);
        set_lane(0, 1, 64'h8000_0010, 32'h0);
        set_lane(1, 1, 64'h8000_0014, 32'h0000_0213);
        step("t4b");
        check_eq("t4b.valid_const", 64'(out_valid), 64'b01);
        check_eq("t4b.pc_const", out_pc[XL-1:0], 64'h8000_0014);

        // Random traffic with a small PC pool so duplicates are common.
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < NC; i++) begin
                logic [IL-1:0] ins;
                int r;
                r   = int'($urandom_range(0, 9));
                ins = $urandom;
                if (r == 0) ins = '0;
`ifdef DIFFTEST_TRAP_EN
                else if (ins == TRAP || ins == '0) ins = 32'h0000_0013;
`else
                else if (r == 1) ins = TRAP;
`endif
                set_lane(i, $urandom_range(0, 3) != 0,
                         64'h8000_0000 + 64'(4 * $urandom_range(0, 7)), ins);
            end
            trap_a0 = {$urandom, $urandom};
            step("rand");
        end

`ifdef DIFFTEST_TRAP_EN
        // Test 5: good trap on lane 0 halts commit and freezes counters.
        trap_a0 = '0;
        set_lane(0, 1, 64'h8000_0100, TRAP);
        set_lane(1, 1, 64'h8000_0104, 32'h0000_0013);
        step("t5");
        check_eq("t5.valid_const", 64'(out_valid), 64'b01);
        check_eq("t5.trap_valid_const", 64'(trap_valid), 64'd1);
        check_eq("t5.trap_code_const", 64'(trap_code), 64'd0);
        check_eq("t5.trap_pc_const", trap_pc, 64'h8000_0100);
        cyc0  = m_cyc;
        icnt0 = m_icnt;
        for (int c = 0; c < 4; c++) begin
            set_lane(0, 1, 64'h8000_0200 + 64'(8 * c), 32'h0000_0013);
            set_lane(1, 1, 64'h8000_0204 + 64'(8 * c), 32'h0000_0093);
            step("t5h");
            check_eq("t5h.valid_const", 64'(out_valid), 64'd0);
        end
        check_eq("t5.cyc_frozen", cycle_cnt, cyc0);
        check_eq("t5.icnt_frozen", instr_cnt, icnt0);
`else
        // Without the trap feature the trap opcode commits like any other.
        set_lane(0, 1, 64'h8000_0100, TRAP);
        set_lane(1, 1, 64'h8000_0104, 32'h0000_0013);
        step("t5");
        check_eq("t5.valid_const", 64'(out_valid), 64'b11);
        check_eq("t5.instr_const", 64'(out_instr[IL-1:0]), 64'(TRAP));
`endif

        // Test 6: asynchronous reset mid-cycle, then a repeat of the last PC.
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        set_lane(0, 1, 64'h8000_0300, 32'h0000_0013);
        set_lane(1, 0, 64'h0, 32'h0);
        step("t6pre");
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all("t6async");
        check_eq("t6async.valid_const", 64'(out_valid), 64'd0);
        check_eq("t6async.icnt_const", instr_cnt, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        set_lane(0, 1, 64'h8000_0300, 32'h0000_0013);
        step("t6post");
        check_eq("t6post.valid_const", 64'(out_valid), 64'b01);
        check_eq("t6post.pc_const", out_pc[XL-1:0], 64'h8000_0300);
        check_eq("t6post.icnt_const", instr_cnt, 64'd1);
        check_eq("t6post.cyc_const", cycle_cnt, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
